// File: rtl/regfile_wb_pkg.sv
// Shared widths, constants and the write-back triple for the integer register file.
// The optional debug read port is enabled by defining RF_DBG_PORT_EN.
package regfile_wb_pkg;

    localparam int REG_BUS_WIDTH      = 32;
    localparam int REG_ADDR_BUS_WIDTH = 5;
    localparam int REG_NUM            = 1 << REG_ADDR_BUS_WIDTH;

    typedef logic [REG_BUS_WIDTH-1:0]      reg_t;
    typedef logic [REG_ADDR_BUS_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG  = 5'd0;
    localparam reg_t      ZERO_WORD = 32'd0;

    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        reg_t      data;
    } wb_t;

endpackage

// File: rtl/regfile_wb_read_port.sv
// One decode-side read port: array lookup with x0 forced to zero, optional same-cycle
// write-through forwarding, and a load-busy flag masked by a same-cycle write-back.
// Latency 0 (purely combinational); no backpressure.
module regfile_wb_read_port
    import regfile_wb_pkg::*;
#(
    parameter int BYPASS = 1
) (
    input  reg_addr_t          addr_i,
    input  reg_t               rf_i [REG_NUM],
    input  logic [REG_NUM-1:0] busy_i,
    input  wb_t                wb_i,
    output reg_t               data_o,
    output logic               busy_o
);

    logic hit;

    assign hit = (BYPASS != 0) && wb_i.we && (wb_i.addr == addr_i);

    always_comb begin
        data_o = rf_i[addr_i];
        if (addr_i == ZERO_REG) begin
            data_o = ZERO_WORD;
        end else if (hit) begin
            data_o = wb_i.data;
        end
    end

    // The write-back landing this cycle resolves the load-use hazard.
    assign busy_o = busy_i[addr_i] & ~hit;

endmodule

// File: rtl/regfile_wb.sv
// Write-back register file (32x32, x0 hardwired to zero) plus load-busy scoreboard;
// writes visible via array next cycle, via bypass same cycle; no backpressure.
// Optional raw debug read port when RF_DBG_PORT_EN is defined.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int BYPASS = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rd_we_i,
    input  reg_t      rd_data_i,
    input  reg_addr_t rd_addr_i,
    input  reg_addr_t rs1_addr_i,
    input  reg_addr_t rs2_addr_i,
    output reg_t      rs1_data_o,
    output reg_t      rs2_data_o,
    input  logic      sb_set_i,
    input  reg_addr_t sb_set_addr_i,
    input  logic      sb_kill_i,
    input  reg_addr_t sb_kill_addr_i,
`ifdef RF_DBG_PORT_EN
    input  reg_addr_t dbg_addr_i,
    output reg_t      dbg_data_o,
`endif
    output logic      rs1_busy_o,
    output logic      rs2_busy_o
);

    reg_t               rf_q [REG_NUM];
    logic [REG_NUM-1:1] busy_q, busy_d;
    logic [REG_NUM-1:0] busy_vec;
    wb_t                wb;

    assign wb       = '{we: rd_we_i, addr: rd_addr_i, data: rd_data_i};
    assign busy_vec = {busy_q, 1'b0};

    // A younger load issued alongside an older load's write-back keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < REG_NUM; i++) begin
            if (sb_set_i && (sb_set_addr_i == reg_addr_t'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((rd_we_i && (rd_addr_i == reg_addr_t'(i))) ||
                         (sb_kill_i && (sb_kill_addr_i == reg_addr_t'(i)))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= ZERO_WORD;
            end
            busy_q <= '0;
        end else begin
            if (rd_we_i && (rd_addr_i != ZERO_REG)) begin
                rf_q[rd_addr_i] <= rd_data_i;
            end
            busy_q <= busy_d;
        end
    end

    regfile_wb_read_port #(.BYPASS(BYPASS)) u_rs1 (
        .addr_i (rs1_addr_i),
        .rf_i   (rf_q),
        .busy_i (busy_vec),
        .wb_i   (wb),
        .data_o (rs1_data_o),
        .busy_o (rs1_busy_o)
    );

    regfile_wb_read_port #(.BYPASS(BYPASS)) u_rs2 (
        .addr_i (rs2_addr_i),
        .rf_i   (rf_q),
        .busy_i (busy_vec),
        .wb_i   (wb),
        .data_o (rs2_data_o),
        .busy_o (rs2_busy_o)
    );

`ifdef RF_DBG_PORT_EN
    assign dbg_data_o = (dbg_addr_i == ZERO_REG) ? ZERO_WORD : rf_q[dbg_addr_i];
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb (BYPASS=1): reset, write/read, x0, bypass,
// scoreboard set/clear/kill priorities and reset overriding concurrent activity.
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      rd_we_i;
    reg_t      rd_data_i;
    reg_addr_t rd_addr_i;
    reg_addr_t rs1_addr_i, rs2_addr_i;
    reg_t      rs1_data_o, rs2_data_o;
    logic      sb_set_i, sb_kill_i;
    reg_addr_t sb_set_addr_i, sb_kill_addr_i;
    logic      rs1_busy_o, rs2_busy_o;
`ifdef RF_DBG_PORT_EN
    reg_addr_t dbg_addr_i;
    reg_t      dbg_data_o;
`endif

    int nerr   = 0;
    int nchecks = 0;

    always #5 clk = ~clk;

    regfile_wb #(.BYPASS(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_we_i        (rd_we_i),
        .rd_data_i      (rd_data_i),
        .rd_addr_i      (rd_addr_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .sb_set_i       (sb_set_i),
        .sb_set_addr_i  (sb_set_addr_i),
        .sb_kill_i      (sb_kill_i),
        .sb_kill_addr_i (sb_kill_addr_i),
`ifdef RF_DBG_PORT_EN
        .dbg_addr_i     (dbg_addr_i),
        .dbg_data_o     (dbg_data_o),
`endif
        .rs1_busy_o     (rs1_busy_o),
        .rs2_busy_o     (rs2_busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_we_i   = 1'b0;
        rd_addr_i = '0;
        rd_data_i = '0;
        sb_set_i  = 1'b0;
        sb_set_addr_i  = '0;
        sb_kill_i = 1'b0;
        sb_kill_addr_i = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        rs1_addr_i = '0;
        rs2_addr_i = '0;
`ifdef RF_DBG_PORT_EN
        dbg_addr_i = '0;
`endif
        tick();
        rst_n = 1'b1;

        // Reset state
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd31; #1;
        chk("rst_rs1_data", rs1_data_o, 32'h0);
        chk("rst_rs2_data", rs2_data_o, 32'h0);
        chk("rst_rs1_busy", {31'b0, rs1_busy_o}, 32'h0);
        chk("rst_rs2_busy", {31'b0, rs2_busy_o}, 32'h0);

        // Write x3, read back next cycle
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
        rd_we_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'hDEADBEEF;
        tick();
        idle(); rs1_addr_i = 5'd3; #1;
        chk("wr_x3_read", rs1_data_o, 32'hDEADBEEF);
        chk("rs2_x0_read", rs2_data_o, 32'h0);

        // Writes to x0 are dropped and never forwarded
        rd_we_i = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'h1234; rs1_addr_i = 5'd0; #1;
        chk("x0_no_bypass", rs1_data_o, 32'h0);
        tick();
        idle(); #1;
        chk("x0_after_wr", rs1_data_o, 32'h0);

        // Same-cycle bypass on both ports
        rd_we_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'hA5A5A5A5;
        rs1_addr_i = 5'd7; rs2_addr_i = 5'd7; #1;
        chk("byp_rs1", rs1_data_o, 32'hA5A5A5A5);
        chk("byp_rs2", rs2_data_o, 32'hA5A5A5A5);
        tick();
        idle(); rs2_addr_i = 5'd3; #1;
        chk("x7_array", rs1_data_o, 32'hA5A5A5A5);
        chk("x3_intact", rs2_data_o, 32'hDEADBEEF);

        // Scoreboard lifecycle on x9
        sb_set_i = 1'b1; sb_set_addr_i = 5'd9; rs1_addr_i = 5'd9; #1;
        chk("sb9_not_yet", {31'b0, rs1_busy_o}, 32'h0);
        tick();
        idle(); #1;
        chk("sb9_busy", {31'b0, rs1_busy_o}, 32'h1);
        rd_we_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h99; #1;
        chk("sb9_wb_mask", {31'b0, rs1_busy_o}, 32'h0);
        chk("sb9_wb_data", rs1_data_o, 32'h99);
        tick();
        idle(); #1;
        chk("sb9_cleared", {31'b0, rs1_busy_o}, 32'h0);

        // Set beats a concurrent write-back
        sb_set_i = 1'b1; sb_set_addr_i = 5'd9;
        rd_we_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h100;
        tick();
        idle(); #1;
        chk("sb9_set_wins", {31'b0, rs1_busy_o}, 32'h1);
        chk("sb9_data_100", rs1_data_o, 32'h100);

        // Kill x12 while x9 stays busy
        sb_set_i = 1'b1; sb_set_addr_i = 5'd12; rs2_addr_i = 5'd12;
        tick();
        idle(); #1;
        chk("sb12_busy", {31'b0, rs2_busy_o}, 32'h1);
        sb_kill_i = 1'b1; sb_kill_addr_i = 5'd12; #1;
        chk("sb12_kill_lat", {31'b0, rs2_busy_o}, 32'h1);
        tick();
        idle(); #1;
        chk("sb12_killed", {31'b0, rs2_busy_o}, 32'h0);
        chk("sb9_kept", {31'b0, rs1_busy_o}, 32'h1);

        // Set on x0 has no effect
        sb_set_i = 1'b1; sb_set_addr_i = 5'd0; rs2_addr_i = 5'd0;
        tick();
        idle(); #1;
        chk("sb0_never", {31'b0, rs2_busy_o}, 32'h0);

        // Reset mid-flight overrides write/set
        rd_we_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h55;
        sb_set_i = 1'b1; sb_set_addr_i = 5'd4;
        tick();
        idle(); rs1_addr_i = 5'd4; rs2_addr_i = 5'd3; #1;
        chk("x4_pre_data", rs1_data_o, 32'h55);
        chk("x4_pre_busy", {31'b0, rs1_busy_o}, 32'h1);
        rst_n = 1'b0;
        rd_we_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h77;
        sb_set_i = 1'b1; sb_set_addr_i = 5'd5;
        tick();
        rst_n = 1'b1; idle(); #1;
        chk("rst_x4_data", rs1_data_o, 32'h0);
        chk("rst_x4_busy", {31'b0, rs1_busy_o}, 32'h0);
        chk("rst_x3_data", rs2_data_o, 32'h0);
        rs2_addr_i = 5'd5; #1;
        chk("rst_x5_busy", {31'b0, rs2_busy_o}, 32'h0);

`ifdef RF_DBG_PORT_EN
        rd_we_i = 1'b1; rd_addr_i = 5'd6; rd_data_i = 32'hCAFE0006; dbg_addr_i = 5'd6; #1;
        chk("dbg_no_bypass", dbg_data_o, 32'h0);
        tick();
        idle(); #1;
        chk("dbg_read", dbg_data_o, 32'hCAFE0006);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
